// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Imported by rr_pick and bus_rr_arbiter.
package bus_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

    function automatic int beat_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational requester picker: round-robin search starting after 'start',
// or fixed lowest-index priority when BUS_ARB_FIXED_PRI_EN is defined.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;

`ifdef BUS_ARB_FIXED_PRI_EN
    logic unused_start;
    assign unused_start = ^start;

    // Descending scan so the lowest requesting index is the one left standing.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end
`else
    // Descending offset scan so the nearest requester after 'start' wins;
    // offset N_REQ wraps back onto 'start' itself.
    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(start) + k) % N_REQ);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter and data mux for a shared bus with bounded tenures.
// Define BUS_ARB_FIXED_PRI_EN for fixed lowest-index priority selection.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         last,
    input  logic [N_REQ*WIDTH-1:0]   data_in,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         bus,
    output logic                     bus_valid,
    output logic [$clog2(N_REQ)-1:0] owner
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = beat_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] owner_n;
    logic [N_REQ-1:0] gnt_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             pick_found;
    logic [IDX_W-1:0] pick_index;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .start (owner),
        .found (pick_found),
        .index (pick_index)
    );

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = state;
        owner_n = owner;
        gnt_n   = gnt;
        cnt_n   = cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_n             = ARB_GRANT;
                    owner_n             = pick_index;
                    gnt_n               = '0;
                    gnt_n[pick_index]   = 1'b1;
                    cnt_n               = '0;
                end
            end
            ARB_GRANT: begin
                // A dropped request ends the tenure without a beat.
                if (!req[owner]) begin
                    state_n = ARB_IDLE;
                    gnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                    if (last[owner] || (cnt_inc == CNT_MAX)) begin
                        state_n = ARB_IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = ARB_IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            owner <= IDX_W'(N_REQ - 1);
            gnt   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            gnt   <= gnt_n;
            cnt   <= cnt_n;
        end
    end

    assign bus_valid = (state == ARB_GRANT) && req[owner];
    assign bus       = (state == ARB_GRANT) ? data_in[int'(owner)*WIDTH +: WIDTH] : '0;

endmodule
